// File: rtl/mc_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mc_cmd_scheduler
// Purpose  : In-order, open-page DRAM command sequencer (ACT/RD/WR/PRE) with
//            per-bank open-row tracking and tRCD/tRP/tRAS/burst spacing.
//            Optional refresh (PREA/REF) is enabled by macro MC_REFRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_cmd_scheduler #(
    parameter int T_RCD   = 39,
    parameter int T_RP    = 39,
    parameter int T_RAS   = 76,
    parameter int T_BURST = 8,
    parameter int T_REFI  = 3900,
    parameter int T_RFC   = 295
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [32:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [14:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done,
    output logic        busy
);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    localparam int GAP_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int GAP_MAX_B = (T_BURST > T_RFC) ? T_BURST : T_RFC;
    localparam int GAP_MAX   = (GAP_MAX_A > GAP_MAX_B) ? GAP_MAX_A : GAP_MAX_B;
    localparam int GAP_W     = $clog2(GAP_MAX + 1);
    localparam int TRAS_W    = $clog2(T_RAS + 1);

    // Counters hold (T-1) so that a command at cycle C permits the next at C+T.
    localparam logic [GAP_W-1:0]  LD_RCD   = GAP_W'(T_RCD - 1);
    localparam logic [GAP_W-1:0]  LD_RP    = GAP_W'(T_RP - 1);
    localparam logic [GAP_W-1:0]  LD_BURST = GAP_W'(T_BURST - 1);
    localparam logic [GAP_W-1:0]  LD_RFC   = GAP_W'(T_RFC - 1);
    localparam logic [TRAS_W-1:0] LD_RAS   = TRAS_W'(T_RAS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCHED    = 3'd1,
        S_PREA     = 3'd2,
        S_REF      = 3'd3,
        S_REF_WAIT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [1:0]         op_q;
    logic [14:0]        row_q;
    logic [9:0]         col_q;
    logic [2:0]         bg_q;
    logic [1:0]         ba_q;
    logic [4:0]         bank;
    logic [31:0]        open_q;
    logic [14:0]        open_row_q [32];
    logic [TRAS_W-1:0]  tras_q [32];
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_ld;
    logic               issue;
    logic [2:0]         cmd_d;
    logic               done_d;
    logic               accept;
    logic               bank_cmd;
    logic               rw_cmd;
    logic               unused_addr;

    assign bank        = {bg_q, ba_q};
    assign accept      = req_valid && ready_q;
    assign req_ready   = ready_q;
    assign busy        = (state_q != S_IDLE);
    assign unused_addr = ^{req_addr[6], req_addr[1:0]};

`ifdef MC_REFRESH_EN
    localparam int                REFI_W  = $clog2(T_REFI + 1);
    localparam logic [REFI_W-1:0] LD_REFI = REFI_W'(T_REFI - 1);

    logic [REFI_W-1:0] refi_q, refi_d;
    logic              refresh_due;
    logic              any_tras;

    always_comb begin
        refi_d = refi_q;
        if (issue && cmd_d == CMD_REF) begin
            refi_d = LD_REFI;
        end else if (refi_q != '0) begin
            refi_d = refi_q - REFI_W'(1);
        end
    end

    always_comb begin
        any_tras = 1'b0;
        for (int i = 0; i < 32; i++) begin
            any_tras = any_tras | (tras_q[i] != '0);
        end
    end

    assign refresh_due = (refi_q == '0);
    assign ready_d     = (state_d == S_IDLE) && (refi_d != '0);

    // Interval counter starts full so that reset is not followed by a refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_q <= LD_REFI;
        end else begin
            refi_q <= refi_d;
        end
    end
`else
    logic [31:0] unused_refi;
    assign unused_refi = 32'(T_REFI);
    assign ready_d     = (state_d == S_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        cmd_d   = CMD_NOP;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef MC_REFRESH_EN
                if (refresh_due) begin
                    state_d = (open_q != '0) ? S_PREA : S_REF;
                end else
`endif
                if (accept) begin
                    state_d = S_SCHED;
                end
            end
            S_SCHED: begin
                if (gap_q == '0) begin
                    if (!open_q[bank]) begin
                        issue = 1'b1;
                        cmd_d = CMD_ACT;
                    end else if (open_row_q[bank] == row_q) begin
                        issue   = 1'b1;
                        cmd_d   = (op_q == 2'd1) ? CMD_WR : CMD_RD;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (tras_q[bank] == '0) begin
                        issue = 1'b1;
                        cmd_d = CMD_PRE;
                    end
                end
            end
`ifdef MC_REFRESH_EN
            S_PREA: begin
                if (gap_q == '0 && !any_tras) begin
                    issue   = 1'b1;
                    cmd_d   = CMD_PREA;
                    state_d = S_REF;
                end
            end
            S_REF: begin
                if (gap_q == '0) begin
                    issue   = 1'b1;
                    cmd_d   = CMD_REF;
                    state_d = S_REF_WAIT;
                end
            end
            S_REF_WAIT: begin
                // Leave one cycle early: the gap reaches 0 as the next request is accepted.
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (cmd_d)
            CMD_ACT:         gap_ld = LD_RCD;
            CMD_RD, CMD_WR:  gap_ld = LD_BURST;
            CMD_REF:         gap_ld = LD_RFC;
            default:         gap_ld = LD_RP;
        endcase
    end

    assign bank_cmd = (cmd_d == CMD_ACT) || (cmd_d == CMD_RD) ||
                      (cmd_d == CMD_WR)  || (cmd_d == CMD_PRE);
    assign rw_cmd   = (cmd_d == CMD_RD)  || (cmd_d == CMD_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            op_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            bg_q      <= '0;
            ba_q      <= '0;
            gap_q     <= '0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bg    <= '0;
            cmd_ba    <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (accept) begin
                op_q  <= req_op;
                row_q <= req_addr[32:18];
                col_q <= {req_addr[17:12], req_addr[5:2]};
                ba_q  <= req_addr[11:10];
                bg_q  <= req_addr[9:7];
            end
            if (issue) begin
                gap_q <= gap_ld;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            cmd_valid <= issue;
            cmd       <= cmd_d;
            done      <= done_d;
            cmd_bg    <= bank_cmd ? bg_q : '0;
            cmd_ba    <= bank_cmd ? ba_q : '0;
            cmd_row   <= (cmd_d == CMD_ACT) ? row_q : '0;
            cmd_col   <= rw_cmd ? col_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= '0;
            for (int i = 0; i < 32; i++) begin
                open_row_q[i] <= '0;
                tras_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (tras_q[i] != '0) begin
                    tras_q[i] <= tras_q[i] - TRAS_W'(1);
                end
            end
            case (cmd_d)
                CMD_ACT: begin
                    open_q[bank]     <= 1'b1;
                    open_row_q[bank] <= row_q;
                    tras_q[bank]     <= LD_RAS;
                end
                CMD_PRE:  open_q[bank] <= 1'b0;
                CMD_PREA: open_q       <= '0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_cmd_scheduler.sv
`default_nettype none
// Directed self-checking bench for mc_cmd_scheduler with short timing parameters.
module tb_mc_cmd_scheduler;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
    localparam logic [2:0] PRE = 3'd4, PREA = 3'd5, REF = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [32:0] req_addr = '0;
    logic        req_ready, cmd_valid, done, busy;
    logic [2:0]  cmd, cmd_bg;
    logic [1:0]  cmd_ba;
    logic [14:0] cmd_row;
    logic [9:0]  cmd_col;

    int checks = 0;
    int passed = 0;

    mc_cmd_scheduler #(
        .T_RCD(3), .T_RP(3), .T_RAS(8), .T_BURST(2)
`ifdef MC_REFRESH_EN
        , .T_REFI(20), .T_RFC(5)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] op, input logic [32:0] addr);
        int n = 0;
        while (!req_ready && n < 60) begin
            step();
            n++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
    endtask

    // Returns edges elapsed until the next command strobe, or -1 on timeout.
    task automatic next_cmd(output int dt);
        dt = 0;
        do begin
            step();
            dt++;
        end while (!cmd_valid && dt < 60);
        if (!cmd_valid) dt = -1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step();
        step();
        checks++; if ({cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, done, busy, req_ready} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, done, busy, req_ready}); else passed++;
        rst_n = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b required 0", cmd_valid); else passed++;
    endtask

    task automatic test_closed_read();
        int dt;
        send(2'd0, 33'h0_0004_0000);
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL closed_busy: got busy=%b ready=%b required busy=1 ready=0", busy, req_ready); else passed++;
        next_cmd(dt);
        checks++; if (dt !== 1) $display("FAIL closed_act_time: got %0d required 1", dt); else passed++;
        checks++; if ({cmd, cmd_bg, cmd_ba, cmd_row} !== {ACT, 3'd0, 2'd0, 15'd1})
            $display("FAIL closed_act: got cmd=%0d bg=%0d ba=%0d row=%0d required ACT bg0 ba0 row1", cmd, cmd_bg, cmd_ba, cmd_row); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL closed_act_done: got %b required 0", done); else passed++;
        next_cmd(dt);
        checks++; if (dt !== 3) $display("FAIL closed_rd_time: got %0d required 3", dt); else passed++;
        checks++; if ({cmd, cmd_col, done} !== {RD, 10'd0, 1'b1})
            $display("FAIL closed_rd: got cmd=%0d col=%0d done=%b required RD col0 done1", cmd, cmd_col, done); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL closed_ready_after: got %b required 1", req_ready); else passed++;
    endtask

    task automatic test_row_hit();
        int dt;
        send(2'd0, 33'h0_0004_0004);
        next_cmd(dt);
        checks++; if (dt !== 1) $display("FAIL hit_rd_time: got %0d required 1", dt); else passed++;
        checks++; if ({cmd, cmd_col, done} !== {RD, 10'd1, 1'b1})
            $display("FAIL hit_rd: got cmd=%0d col=%0d done=%b required RD col1 done1", cmd, cmd_col, done); else passed++;
    endtask

    task automatic test_row_miss();
        int dt;
        send(2'd1, 33'h0_0008_0000);
        next_cmd(dt);
        checks++; if (dt !== 2) $display("FAIL miss_pre_time: got %0d required 2", dt); else passed++;
        checks++; if ({cmd, cmd_bg, cmd_ba, done} !== {PRE, 3'd0, 2'd0, 1'b0})
            $display("FAIL miss_pre: got cmd=%0d bg=%0d ba=%0d done=%b required PRE bg0 ba0", cmd, cmd_bg, cmd_ba, done); else passed++;
        next_cmd(dt);
        checks++; if (dt !== 3) $display("FAIL miss_act_time: got %0d required 3", dt); else passed++;
        checks++; if ({cmd, cmd_row} !== {ACT, 15'd2})
            $display("FAIL miss_act: got cmd=%0d row=%0d required ACT row2", cmd, cmd_row); else passed++;
        next_cmd(dt);
        checks++; if (dt !== 3) $display("FAIL miss_wr_time: got %0d required 3", dt); else passed++;
        checks++; if ({cmd, cmd_col, done} !== {WR, 10'd0, 1'b1})
            $display("FAIL miss_wr: got cmd=%0d col=%0d done=%b required WR col0 done1", cmd, cmd_col, done); else passed++;
    endtask

    task automatic test_bank_indep();
        int dt;
        do_reset();
        send(2'd0, 33'h0_0004_0000);
        next_cmd(dt);
        next_cmd(dt);
        checks++; if ({dt, cmd} !== {32'd3, RD}) $display("FAIL indep_first_rd: got dt=%0d cmd=%0d required 3 RD", dt, cmd); else passed++;
        send(2'd1, 33'h0_0004_0080);
        next_cmd(dt);
        checks++; if ({dt, cmd, cmd_bg, cmd_ba, cmd_row} !== {32'd1, ACT, 3'd1, 2'd0, 15'd1})
            $display("FAIL indep_act_bg1: got dt=%0d cmd=%0d bg=%0d ba=%0d row=%0d required 1 ACT bg1 ba0 row1", dt, cmd, cmd_bg, cmd_ba, cmd_row); else passed++;
        next_cmd(dt);
        checks++; if ({dt, cmd, cmd_bg, done} !== {32'd3, WR, 3'd1, 1'b1})
            $display("FAIL indep_wr_bg1: got dt=%0d cmd=%0d bg=%0d done=%b required 3 WR bg1 done1", dt, cmd, cmd_bg, done); else passed++;
        send(2'd2, 33'h0_0004_0000);
        next_cmd(dt);
        checks++; if ({dt, cmd, cmd_bg, done} !== {32'd1, RD, 3'd0, 1'b1})
            $display("FAIL indep_bg0_hit: got dt=%0d cmd=%0d bg=%0d done=%b required 1 RD bg0 done1", dt, cmd, cmd_bg, done); else passed++;
    endtask

    task automatic test_reset_midop();
        int dt;
        logic seen;
        do_reset();
        send(2'd0, 33'h0_0004_0000);
        next_cmd(dt);
        checks++; if ({dt, cmd} !== {32'd1, ACT}) $display("FAIL midop_act: got dt=%0d cmd=%0d required 1 ACT", dt, cmd); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_valid, cmd, cmd_row, busy, req_ready} !== '0)
            $display("FAIL midop_async_clear: got valid=%b cmd=%0d row=%0d busy=%b ready=%b required all 0", cmd_valid, cmd, cmd_row, busy, req_ready); else passed++;
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | cmd_valid | done;
        end
        checks++; if (seen !== 1'b0) $display("FAIL midop_no_cmd: got %b required 0", seen); else passed++;
        send(2'd0, 33'h0_0004_0000);
        next_cmd(dt);
        checks++; if ({dt, cmd, cmd_row} !== {32'd1, ACT, 15'd1})
            $display("FAIL midop_replay_act: got dt=%0d cmd=%0d row=%0d required 1 ACT row1", dt, cmd, cmd_row); else passed++;
        next_cmd(dt);
        checks++; if ({dt, cmd, done} !== {32'd3, RD, 1'b1})
            $display("FAIL midop_replay_rd: got dt=%0d cmd=%0d done=%b required 3 RD done1", dt, cmd, done); else passed++;
    endtask

`ifdef MC_REFRESH_EN
    task automatic test_refresh();
        int dt;
        do_reset();
        repeat (15) step();
        send(2'd0, 33'h0_0004_0000);
        next_cmd(dt);
        checks++; if ({dt, cmd} !== {32'd1, ACT}) $display("FAIL ref_req_act: got dt=%0d cmd=%0d required 1 ACT", dt, cmd); else passed++;
        next_cmd(dt);
        checks++; if ({dt, cmd, done} !== {32'd3, RD, 1'b1}) $display("FAIL ref_req_rd: got dt=%0d cmd=%0d done=%b required 3 RD 1", dt, cmd, done); else passed++;
        checks++; if (req_ready !== 1'b0) $display("FAIL ref_pending_ready: got %b required 0", req_ready); else passed++;
        next_cmd(dt);
        checks++; if ({dt, cmd} !== {32'd5, PREA}) $display("FAIL ref_prea: got dt=%0d cmd=%0d required 5 PREA", dt, cmd); else passed++;
        next_cmd(dt);
        checks++; if ({dt, cmd} !== {32'd3, REF}) $display("FAIL ref_ref: got dt=%0d cmd=%0d required 3 REF", dt, cmd); else passed++;
        repeat (3) step();
        checks++; if (req_ready !== 1'b0) $display("FAIL ref_ready_hold: got %b required 0", req_ready); else passed++;
        step();
        checks++; if (req_ready !== 1'b1) $display("FAIL ref_ready_return: got %b required 1", req_ready); else passed++;
        send(2'd0, 33'h0_0004_0000);
        next_cmd(dt);
        checks++; if ({dt, cmd, cmd_row} !== {32'd1, ACT, 15'd1})
            $display("FAIL ref_reopen_act: got dt=%0d cmd=%0d row=%0d required 1 ACT row1", dt, cmd, cmd_row); else passed++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef MC_REFRESH_EN
        test_refresh();
`else
        test_closed_read();
        test_row_hit();
        test_row_miss();
        test_bank_indep();
        test_reset_midop();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_cmd_scheduler.md
Name: mc_cmd_scheduler

Overview:
- Sequences one memory-controller queue entry at a time into DRAM commands (ACT/RD/WR/PRE) under an open-page policy.
- Sits between the 16-entry MC request queue (head entry: 2-bit op + 33-bit address) and the DRAM command bus.
- Tracks the open row of each of 32 banks and enforces tRCD, tRP, tRAS and burst spacing.
- Requests are serviced strictly in order.

Parameters:
- T_RCD, 39: minimum cycles from ACT to RD/WR, same bank.
- T_RP, 39: minimum cycles from PRE to the next ACT.
- T_RAS, 76: minimum cycles from ACT to PRE, same bank.
- T_BURST, 8: minimum cycles from RD/WR to the next command.
- T_REFI, 3900: refresh interval (MC_REFRESH_EN only).
- T_RFC, 295: cycles from REF to the next command (MC_REFRESH_EN only).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: queue head valid.
- req_ready, output, 1: scheduler accepts the head entry.
- req_op, input, 2: 0 data read, 1 data write, 2 instruction fetch, 3 treated as read.
- req_addr, input, 33: physical address.
- cmd_valid, output, 1: command strobe (1 cycle).
- cmd, output, 3: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF.
- cmd_bg, output, 3: bank group.
- cmd_ba, output, 2: bank.
- cmd_row, output, 15: row.
- cmd_col, output, 10: column.
- done, output, 1: 1-cycle pulse when the request's RD/WR issues.
- busy, output, 1: state is not IDLE.

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except req_ready=1 once out of reset. All banks closed, all counters 0, state IDLE.
- Address map:
  - row = addr[32:18]
  - col = {addr[17:12], addr[5:2]}
  - ba = addr[11:10]
  - bg = addr[9:7]
  - addr[6] and addr[1:0] ignored.
  - Bank index = {bg, ba}.
- Handshake:
  - Entry transfers on req_valid & req_ready.
  - req_ready = (state==IDLE) and no refresh pending.
  - Op and address are registered on accept.
- Gap counter:
  - Loaded on each issued command: T_RP after PRE/PREA, T_RCD after ACT, T_BURST after RD/WR, T_RFC after REF.
  - A command issued at cycle C is followed by the next command no earlier than C+load.
  - Saturating decrement at 0.
- Per-bank tRAS counter: loaded with T_RAS on ACT to that bank; PRE is legal only when it is 0.
- State machine:
  - IDLE → SCHED on accept.
  - SCHED, open-row hit: issue RD/WR when gap==0, pulse done, → IDLE.
  - SCHED, bank closed: issue ACT when gap==0, mark open with row, stay in SCHED.
  - SCHED, different row open: issue PRE when gap==0 and bank tRAS==0, mark closed, stay in SCHED.
- Earliest issue: the first command may issue the cycle after accept. req_ready returns the cycle after done.
- Outputs: cmd/bg/ba/row/col are registered and valid only while cmd_valid=1; otherwise driven 0.
- At most one command per cycle.
- Reset mid-operation: request dropped, no done, open-row table cleared, counters cleared.

Optional Feature:
- Macro: MC_REFRESH_EN.
- With macro defined:
  - A T_REFI down-counter, reloaded on REF, sets refresh pending at 0.
  - Pending is honoured only in IDLE and has priority over a simultaneous req_valid.
  - Sequence: PREA (gap==0 and all tRAS==0; skipped if all banks closed) → REF (gap==0) → all banks closed → IDLE.
- Without macro: no refresh logic; cmd never 5 or 6; req_ready depends on state only.

Test Plan:
- Parameter overrides for all scenarios: T_RCD=3, T_RP=3, T_RAS=8, T_BURST=2. Accept of the first request is cycle 0.
- Reset: rst_n low → all outputs 0. rst_n high → req_ready=1, busy=0.
- Closed-bank read: op 0, addr 0x000040000 (row1, bg0, ba0, col0) → ACT row1 @1, RD col0 @4, done @4, req_ready @5.
- Row hit: op 0, addr 0x000040004 accepted @5 → RD col1 @6, no ACT/PRE.
- Row miss: op 1, addr 0x000080000 accepted @7 → PRE @9 (tRAS since ACT@1), ACT row2 @12, WR @15, done @15.
- Bank independence: write to 0x000040080 (bg1) while bg0 row1 open → ACT bg1 then WR; bg0 stays open, and a later read to row1 bg0 is a direct RD.
- Reset between ACT and RD → no RD, no done. Same request replayed → fresh ACT issued.
- With MC_REFRESH_EN, T_REFI=20, T_RFC=5:
  - Refresh pending while a request is in flight → PREA after done, then REF 3 cycles later.
  - req_ready=0 until 5 cycles after REF.
  - Next request to a previously open row issues ACT.
